// File: rtl/testchip_testclk_ctrl.sv
// rtl/testchip_testclk_ctrl.sv - glitch-safe test-clock select/enable switch sequencer
module testchip_testclk_ctrl #(
  parameter int GATE_WAIT   = 8,
  parameter int SETTLE_WAIT = 8,
  parameter int START_WAIT  = 4,
  parameter int CNT_W       = 8
) (
  input  logic       cdb_pclk,
  input  logic       reset_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_sel,
  input  logic       cfg_en,
  output logic [3:0] test_clk_sel,
  output logic       test_clk_en,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    RUN       = 3'd1,
    STOP_WAIT = 3'd2,
    SEL_WAIT  = 3'd3,
    EN_WAIT   = 3'd4
  } state_t;

  // Counters load N-1 so each wait state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_WAIT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_WAIT - 1);
  localparam logic [CNT_W-1:0] START_LD  = CNT_W'(START_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sel_q, sel_d;
  logic [3:0]       req_sel_q, req_sel_d;
  logic             req_en_q, req_en_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             cnt_zero;

  assign accept   = cfg_valid & ready_q;
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    en_d      = en_q;
    req_sel_d = req_sel_q;
    req_en_d  = req_en_q;
    done_d    = 1'b0;

    case (state_q)
      OFF: begin
        if (accept) begin
          req_sel_d = cfg_sel;
          req_en_d  = cfg_en;
          sel_d     = cfg_sel;
          cnt_d     = SETTLE_LD;
          state_d   = SEL_WAIT;
        end
      end
      RUN: begin
        if (accept) begin
          req_sel_d = cfg_sel;
          req_en_d  = cfg_en;
          if (cfg_en && (cfg_sel == sel_q)) begin
            done_d = 1'b1;
          end else begin
            en_d    = 1'b0;
            cnt_d   = GATE_LD;
            state_d = STOP_WAIT;
          end
        end
      end
      STOP_WAIT: begin
        if (cnt_zero) begin
          sel_d   = req_sel_q;
          cnt_d   = SETTLE_LD;
          state_d = SEL_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SEL_WAIT: begin
        if (cnt_zero) begin
          if (req_en_q) begin
            en_d    = 1'b1;
            cnt_d   = START_LD;
            state_d = EN_WAIT;
          end else begin
            done_d  = 1'b1;
            state_d = OFF;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      EN_WAIT: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = OFF;
      end
    endcase

    ready_d = (state_d == OFF) || (state_d == RUN);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge cdb_pclk) begin
    if (!reset_n) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      sel_q     <= 4'h0;
      en_q      <= 1'b0;
      req_sel_q <= 4'h0;
      req_en_q  <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      req_sel_q <= req_sel_d;
      req_en_q  <= req_en_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign cfg_ready    = ready_q;
  assign test_clk_sel = sel_q;
  assign test_clk_en  = en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_testchip_testclk_ctrl.sv
// tb/tb_testchip_testclk_ctrl.sv - directed self-checking bench for testchip_testclk_ctrl
module tb_testchip_testclk_ctrl;

  logic       cdb_pclk = 1'b0;
  logic       reset_n  = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_sel = 4'h0;
  logic       cfg_en  = 1'b0;
  logic [3:0] test_clk_sel;
  logic       test_clk_en;
  logic       busy;
  logic       done;
  logic [2:0] state_o;

  localparam logic [2:0] S_OFF = 3'd0, S_RUN = 3'd1, S_STOP = 3'd2, S_SEL = 3'd3, S_EN = 3'd4;

  typedef struct {
    int         cyc;
    logic [3:0] sel;
    logic       en;
    logic [2:0] st;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         errors  = 0;
  int         cyc     = 0;
  logic [3:0] prev_sel = 4'h0;

  testchip_testclk_ctrl dut (
    .cdb_pclk    (cdb_pclk),
    .reset_n     (reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_sel     (cfg_sel),
    .cfg_en      (cfg_en),
    .test_clk_sel(test_clk_sel),
    .test_clk_en (test_clk_en),
    .busy        (busy),
    .done        (done),
    .state_o     (state_o)
  );

  always #5 cdb_pclk = ~cdb_pclk;
  always @(posedge cdb_pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cdb_pclk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int c, input logic [3:0] s, input logic e, input logic [2:0] st);
    exp_t x;
    x.cyc = c; x.sel = s; x.en = e; x.st = st;
    sb.push_back(x);
  endtask

  // Returns the cycle in which the request was accepted; returns at accept+1.
  task automatic do_req(input logic [3:0] s, input logic e, output int acc);
    int n;
    n = 0;
    cfg_valid = 1'b1; cfg_sel = s; cfg_en = e;
    while (!cfg_ready && n < 200) begin tick(); n++; end
    check("req_ready_timeout", {31'b0, cfg_ready}, 32'd1);
    acc = cyc;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Scoreboard consumer plus the select-vs-enable safety invariant.
  always @(negedge cdb_pclk) begin
    exp_t x;
    if (test_clk_sel !== prev_sel) check("sel_change_while_en", {31'b0, test_clk_en}, 32'd0);
    prev_sel = test_clk_sel;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("done_unexpected", {31'b0, done}, 32'd0);
      end else begin
        x = sb.pop_front();
        check("done_cycle", cyc, x.cyc);
        check("done_sel", {28'b0, test_clk_sel}, {28'b0, x.sel});
        check("done_en", {31'b0, test_clk_en}, {31'b0, x.en});
        check("done_state", {29'b0, state_o}, {29'b0, x.st});
        check("done_ready", {31'b0, cfg_ready}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b;
    // Reset state
    tick(); tick(); tick();
    check("rst_sel", {28'b0, test_clk_sel}, 32'h0);
    check("rst_en", {31'b0, test_clk_en}, 32'd0);
    check("rst_ready", {31'b0, cfg_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_state", {29'b0, state_o}, {29'b0, S_OFF});
    reset_n = 1'b1;
    tick(); tick();

    // OFF -> sel 3 enabled
    do_req(4'h3, 1'b1, a);
    push(a + 13, 4'h3, 1'b1, S_RUN);
    check("t1_sel", {28'b0, test_clk_sel}, 32'h3);
    check("t1_state", {29'b0, state_o}, {29'b0, S_SEL});
    check("t1_ready_lo", {31'b0, cfg_ready}, 32'd0);
    check("t1_busy", {31'b0, busy}, 32'd1);
    wait_to(a + 8);
    check("t1_en_still_lo", {31'b0, test_clk_en}, 32'd0);
    wait_to(a + 9);
    check("t1_en_rise", {31'b0, test_clk_en}, 32'd1);
    check("t1_state_en", {29'b0, state_o}, {29'b0, S_EN});
    wait_to(a + 12);
    check("t1_ready_lo_end", {31'b0, cfg_ready}, 32'd0);
    wait_to(a + 13);
    check("t1_done", {31'b0, done}, 32'd1);

    // RUN sel 3 -> sel 8 enabled
    wait_to(a + 15);
    do_req(4'h8, 1'b1, a);
    push(a + 21, 4'h8, 1'b1, S_RUN);
    check("t2_en_fall", {31'b0, test_clk_en}, 32'd0);
    check("t2_state", {29'b0, state_o}, {29'b0, S_STOP});
    wait_to(a + 8);
    check("t2_sel_hold", {28'b0, test_clk_sel}, 32'h3);
    wait_to(a + 9);
    check("t2_sel_new", {28'b0, test_clk_sel}, 32'h8);
    wait_to(a + 16);
    check("t2_en_still_lo", {31'b0, test_clk_en}, 32'd0);
    wait_to(a + 17);
    check("t2_en_rise", {31'b0, test_clk_en}, 32'd1);
    wait_to(a + 21);
    check("t2_done", {31'b0, done}, 32'd1);

    // RUN sel 8 -> same request is a no-op
    wait_to(a + 23);
    do_req(4'h8, 1'b1, a);
    push(a + 1, 4'h8, 1'b1, S_RUN);
    check("t3_done", {31'b0, done}, 32'd1);
    check("t3_en", {31'b0, test_clk_en}, 32'd1);
    check("t3_state", {29'b0, state_o}, {29'b0, S_RUN});
    tick();
    check("t3_done_pulse", {31'b0, done}, 32'd0);

    // RUN -> sel 5 disabled
    do_req(4'h5, 1'b0, a);
    push(a + 17, 4'h5, 1'b0, S_OFF);
    check("t4_en_fall", {31'b0, test_clk_en}, 32'd0);
    wait_to(a + 9);
    check("t4_sel", {28'b0, test_clk_sel}, 32'h5);
    wait_to(a + 17);
    check("t4_done", {31'b0, done}, 32'd1);
    check("t4_en_lo", {31'b0, test_clk_en}, 32'd0);

    // Held request during busy, back-to-back accept on the done cycle
    wait_to(a + 19);
    cfg_valid = 1'b1; cfg_sel = 4'h1; cfg_en = 1'b1;
    a = cyc;
    tick();
    push(a + 13, 4'h1, 1'b1, S_RUN);
    for (int k = 0; k < 12; k++) begin
      cfg_sel = (k < 5) ? 4'(k + 9) : 4'h2;
      cfg_en  = (k < 5) ? k[0] : 1'b1;
      check("t5_ready_lo", {31'b0, cfg_ready}, 32'd0);
      check("t5_busy", {31'b0, busy}, 32'd1);
      tick();
    end
    check("t5_done_cycle", cyc, a + 13);
    check("t5_done", {31'b0, done}, 32'd1);
    check("t5_ready_on_done", {31'b0, cfg_ready}, 32'd1);
    b = cyc;
    tick();
    cfg_valid = 1'b0;
    push(b + 21, 4'h2, 1'b1, S_RUN);
    check("t5_second_accept", {29'b0, state_o}, {29'b0, S_STOP});
    check("t5_en_fall", {31'b0, test_clk_en}, 32'd0);
    check("t5_sel_kept", {28'b0, test_clk_sel}, 32'h1);
    wait_to(b + 22);
    check("t5_sel_final", {28'b0, test_clk_sel}, 32'h2);

    // Reset during SEL_WAIT discards the request
    do_req(4'h6, 1'b1, a);
    wait_to(a + 10);
    check("t6_in_sel_wait", {29'b0, state_o}, {29'b0, S_SEL});
    reset_n = 1'b0;
    tick();
    check("t6_sel", {28'b0, test_clk_sel}, 32'h0);
    check("t6_en", {31'b0, test_clk_en}, 32'd0);
    check("t6_state", {29'b0, state_o}, {29'b0, S_OFF});
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_done", {31'b0, done}, 32'd0);
    reset_n = 1'b1;
    repeat (30) tick();
    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
